tape_saver: RTL
===============

TAPE_SAVER -- requirements
Module: tape_saver

Interface
REQ-001 SYNC_LEN, 4, number of 0x16 sync bytes emitted before the 0x24 marker; legal range 1..16.
REQ-002 clk  in  1  sole clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 arm  in  1  one-cycle pulse; latches the save parameters below.
REQ-005 start_addr / end_addr  in  16 each  inclusive RAM range to save.
REQ-006 mc_type  in  1  1 = machine code (type byte 0x80), 0 = BASIC (0x00).
REQ-007 autorun  in  1  1 = autorun byte 0xC7, 0 = 0x00.
REQ-008 ioctl_upload  in  1  host upload session active.
REQ-009 ioctl_rd  in  1  one-cycle host read strobe for byte at ioctl_addr.
REQ-010 ioctl_addr  in  25  byte offset into generated TAP image.
REQ-011 ioctl_din  out  8  byte returned to host.
REQ-012 ioctl_wait  out  1  host must stall while high.
REQ-013 ram_addr  out  16 / ram_rd  out  1 / ram_q  in  8  RAM read port; registered RAM, ram_q valid one cycle after ram_rd.
REQ-014 file_size  out  25  total TAP image length in bytes.
REQ-015 armed / range_err  out  1 each  parameters valid / last arm had end_addr < start_addr.

Function
REQ-016 Image layout: offsets 0..SYNC_LEN-1 = 0x16; then 0x24, 0x00, 0x00, type, autorun, end hi, end lo, start hi, start lo, 0x00 (header block H = SYNC_LEN+10 bytes); then name bytes, then 0x00 terminator; then RAM[start_addr..end_addr].
REQ-017 file_size = H + N + 1 + (end_addr - start_addr + 1), N = name length (0 without name feature); computed in the arm+1 cycle using 17-bit subtraction.
REQ-018 arm with end_addr < start_addr sets range_err=1, armed=0, file_size=0.
REQ-019 arm is ignored while ioctl_upload=1; parameters stay stable for the whole session.
REQ-020 FSM states: IDLE, HDR, RAM_REQ, RAM_WAIT, RESP; IDLE on reset.
REQ-021 ioctl_rd in cycle T at a non-RAM offset (header, name, terminator, offset >= file_size, or not armed): ioctl_din updated in T+1, ioctl_wait never asserted (IDLE->HDR->IDLE).
REQ-022 ioctl_rd in cycle T at a RAM offset: ram_addr = start_addr + (offset - H - N - 1), ram_rd=1 in T+1 (RAM_REQ); ioctl_wait=1 in T+1 and T+2; ram_q captured in T+2 (RAM_WAIT); ioctl_din valid and ioctl_wait=0 from T+3 (RESP->IDLE).
REQ-023 Offset >= file_size or not armed returns 0x00, no RAM access.
REQ-024 ioctl_rd while FSM is not IDLE is ignored (host contract violation; no state corruption).
REQ-025 ram_addr arithmetic wraps modulo 2^16; end_addr=0xFFFF reads through 0xFFFF without wrap to 0.
REQ-026 ioctl_upload falling edge mid-RAM-fetch aborts to IDLE next cycle, ioctl_wait=0; armed unchanged.
REQ-027 ram_rd is high only in RAM_REQ; ioctl_din holds last value otherwise.

Reset
REQ-028 Reset in any cycle: FSM=IDLE, ioctl_din=0x00, ioctl_wait=0, ram_rd=0, ram_addr=0, file_size=0, armed=0, range_err=0, latched parameters cleared; a pending fetch is dropped.

Configuration
REQ-029 TAPE_SAVER_NAME_EN defined: extra input file_name (128 bits, byte 0 in bits 7:0); N = count of bytes before first 0x00 (max 16), latched on arm.
REQ-030 TAPE_SAVER_NAME_EN undefined: no file_name port, N=0, terminator directly after header.

Structure
REQ-031 Shared package tape_pkg: sync byte 0x16, marker 0x24, type codes 0x00/0x80, autorun codes 0x00/0xC7, FSM state enum, header field offsets; also used by the cassette loader.
REQ-032 One sub-module tape_hdr_rom: combinational header/name byte select from offset and latched parameters.

Verification
REQ-033 arm start=0x0501 end=0x0600 mc=0 autorun=1, SYNC_LEN=4, no name -> file_size=271, offsets 0..14 = 16 16 16 16 24 00 00 00 C7 06 00 05 01 00 00, no wait.
REQ-034 same, read offset 15 with RAM[0x0501]=0xA5 -> ram_rd at T+1 addr 0x0501, wait high T+1..T+2, ioctl_din=0xA5 at T+3.
REQ-035 arm start=0x1000 end=0x0FFF -> range_err=1, file_size=0, read offset 0 returns 0x00, no ram_rd.
REQ-036 start=0xFFF0 end=0xFFFF, read last offset (30) -> ram_addr 0xFFFF; read offset 31 -> 0x00, no ram_rd.
REQ-037 With TAPE_SAVER_NAME_EN, name "GAME" -> offsets 14..18 = 47 41 4D 45 00, first data at offset 19, file_size grows by 4.
REQ-038 reset asserted in T+2 of a RAM fetch -> ioctl_wait=0, ram_rd=0, armed=0 in following cycle; arm during ioctl_upload=1 ignored.

Source files
------------

// File: rtl/tape_pkg.sv
// Shared TAP format constants, header field offsets and FSM state type,
// used by the tape saver and the cassette loader.
package tape_pkg;

   localparam logic [7:0] SYNC_BYTE   = 8'h16;
   localparam logic [7:0] MARKER_BYTE = 8'h24;
   localparam logic [7:0] TYPE_BASIC  = 8'h00;
   localparam logic [7:0] TYPE_MC     = 8'h80;
   localparam logic [7:0] AUTORUN_OFF = 8'h00;
   localparam logic [7:0] AUTORUN_ON  = 8'hC7;

   // Header fields following the sync run; offsets relative to the marker.
   localparam int         HDR_FIELDS   = 10;
   localparam logic [3:0] FLD_MARKER   = 4'd0;
   localparam logic [3:0] FLD_TYPE     = 4'd3;
   localparam logic [3:0] FLD_AUTORUN  = 4'd4;
   localparam logic [3:0] FLD_END_HI   = 4'd5;
   localparam logic [3:0] FLD_END_LO   = 4'd6;
   localparam logic [3:0] FLD_START_HI = 4'd7;
   localparam logic [3:0] FLD_START_LO = 4'd8;

   localparam int NAME_MAX = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_RAM_REQ,
      ST_RAM_WAIT,
      ST_RESP
   } tape_state_e;

   // Number of name bytes before the first NUL, capped at NAME_MAX.
   function automatic logic [4:0] name_length(input logic [127:0] name);
      logic [4:0] n;
      logic       hit;
      n   = 5'd0;
      hit = 1'b0;
      for (int i = 0; i < NAME_MAX; i++) begin
         if (!hit && name[8*i +: 8] != 8'h00) n = n + 5'd1;
         else hit = 1'b1;
      end
      return n;
   endfunction

endpackage

// File: rtl/tape_hdr_rom.sv
// Combinational byte select for the sync run, header fields, name and
// terminator of a TAP image, from the image offset and latched parameters.
module tape_hdr_rom
   import tape_pkg::*;
#(
   parameter int SYNC_LEN = 4
) (
   input  logic [24:0]  offset_i,
   input  logic [15:0]  start_i,
   input  logic [15:0]  end_i,
   input  logic         mc_i,
   input  logic         autorun_i,
   input  logic [4:0]   name_len_i,
   input  logic [127:0] name_i,
   output logic [7:0]   byte_o
);

   localparam logic [24:0] SYNC_END = 25'(SYNC_LEN);
   localparam logic [24:0] HDR_LEN  = 25'(SYNC_LEN + HDR_FIELDS);

   logic [3:0] fld;
   logic [3:0] name_idx;

   always_comb begin
      byte_o   = 8'h00;
      fld      = 4'(offset_i - SYNC_END);
      name_idx = 4'(offset_i - HDR_LEN);
      if (offset_i < SYNC_END) begin
         byte_o = SYNC_BYTE;
      end else if (offset_i < HDR_LEN) begin
         case (fld)
            FLD_MARKER:   byte_o = MARKER_BYTE;
            FLD_TYPE:     byte_o = mc_i ? TYPE_MC : TYPE_BASIC;
            FLD_AUTORUN:  byte_o = autorun_i ? AUTORUN_ON : AUTORUN_OFF;
            FLD_END_HI:   byte_o = end_i[15:8];
            FLD_END_LO:   byte_o = end_i[7:0];
            FLD_START_HI: byte_o = start_i[15:8];
            FLD_START_LO: byte_o = start_i[7:0];
            default:      byte_o = 8'h00;
         endcase
      end else if (offset_i < HDR_LEN + {20'd0, name_len_i}) begin
         byte_o = name_i[{name_idx, 3'b000} +: 8];
      end
   end

endmodule

// File: rtl/tape_saver.sv
// Serves a TAP image of a RAM range to the host upload port, byte by byte.
// Optional file name support is enabled with TAPE_SAVER_NAME_EN.
module tape_saver
   import tape_pkg::*;
#(
   parameter int SYNC_LEN = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         arm,
   input  logic [15:0]  start_addr,
   input  logic [15:0]  end_addr,
   input  logic         mc_type,
   input  logic         autorun,
   input  logic         ioctl_upload,
   input  logic         ioctl_rd,
   input  logic [24:0]  ioctl_addr,
`ifdef TAPE_SAVER_NAME_EN
   input  logic [127:0] file_name,
`endif
   output logic [7:0]   ioctl_din,
   output logic         ioctl_wait,
   output logic [15:0]  ram_addr,
   output logic         ram_rd,
   input  logic [7:0]   ram_q,
   output logic [24:0]  file_size,
   output logic         armed,
   output logic         range_err,
   output tape_state_e  dbg_state
);

   localparam logic [24:0] HDR_LEN = 25'(SYNC_LEN + HDR_FIELDS);

   logic [15:0]  start_q, end_q;
   logic         mc_q, autorun_q, calc_q, armed_q, range_err_q, upload_q;
   logic [24:0]  size_q;
   logic [127:0] name_w;
   logic [4:0]   name_len_w;
   logic [16:0]  diff17;
   logic [24:0]  data_base;
   logic         is_ram, in_image, abort;
   logic [7:0]   hdr_byte;
   tape_state_e  state_q, state_d;
   logic [7:0]   din_q, din_d;
   logic [15:0]  ram_addr_q, ram_addr_d;

`ifdef TAPE_SAVER_NAME_EN
   logic [127:0] name_q;
   logic [4:0]   name_len_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         name_q     <= '0;
         name_len_q <= '0;
      end else if (arm && !ioctl_upload) begin
         name_q     <= file_name;
         name_len_q <= name_length(file_name);
      end
   end
   assign name_w     = name_q;
   assign name_len_w = name_len_q;
`else
   assign name_w     = '0;
   assign name_len_w = '0;
`endif

   // Parameters latch on arm; the size and range check settle one cycle later.
   assign diff17 = {1'b0, end_q} - {1'b0, start_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         start_q     <= '0;
         end_q       <= '0;
         mc_q        <= 1'b0;
         autorun_q   <= 1'b0;
         calc_q      <= 1'b0;
         armed_q     <= 1'b0;
         range_err_q <= 1'b0;
         size_q      <= '0;
      end else begin
         calc_q <= 1'b0;
         if (arm && !ioctl_upload) begin
            start_q     <= start_addr;
            end_q       <= end_addr;
            mc_q        <= mc_type;
            autorun_q   <= autorun;
            calc_q      <= 1'b1;
            armed_q     <= 1'b0;
            range_err_q <= 1'b0;
            size_q      <= '0;
         end else if (calc_q) begin
            if (diff17[16]) begin
               range_err_q <= 1'b1;
            end else begin
               armed_q <= 1'b1;
               size_q  <= HDR_LEN + {20'd0, name_len_w} + {8'd0, diff17} + 25'd2;
            end
         end
      end
   end

   tape_hdr_rom #(.SYNC_LEN(SYNC_LEN)) u_hdr_rom (
      .offset_i   (ioctl_addr),
      .start_i    (start_q),
      .end_i      (end_q),
      .mc_i       (mc_q),
      .autorun_i  (autorun_q),
      .name_len_i (name_len_w),
      .name_i     (name_w),
      .byte_o     (hdr_byte)
   );

   assign data_base = HDR_LEN + {20'd0, name_len_w} + 25'd1;
   assign in_image  = armed_q && (ioctl_addr < size_q);
   assign is_ram    = in_image && (ioctl_addr >= data_base);
   assign abort     = upload_q && !ioctl_upload;

   // Host handshake: ioctl_rd is a one-cycle request accepted only in IDLE;
   // ioctl_din is valid in the first cycle after the request in which
   // ioctl_wait is low, and holds until the next accepted request.
   always_comb begin
      state_d    = state_q;
      din_d      = din_q;
      ram_addr_d = ram_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (ioctl_rd) begin
               if (is_ram) begin
                  state_d    = ST_RAM_REQ;
                  ram_addr_d = start_q + 16'(ioctl_addr - data_base);
               end else begin
                  state_d = ST_HDR;
                  din_d   = in_image ? hdr_byte : 8'h00;
               end
            end
         end
         ST_HDR:      state_d = ST_IDLE;
         ST_RAM_REQ:  state_d = abort ? ST_IDLE : ST_RAM_WAIT;
         ST_RAM_WAIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
               din_d   = ram_q;
            end
         end
         ST_RESP:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         din_q      <= 8'h00;
         ram_addr_q <= '0;
         upload_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         din_q      <= din_d;
         ram_addr_q <= ram_addr_d;
         upload_q   <= ioctl_upload;
      end
   end

   assign ioctl_din  = din_q;
   assign ioctl_wait = (state_q == ST_RAM_REQ) || (state_q == ST_RAM_WAIT);
   assign ram_rd     = (state_q == ST_RAM_REQ);
   assign ram_addr   = ram_addr_q;
   assign file_size  = size_q;
   assign armed      = armed_q;
   assign range_err  = range_err_q;
   assign dbg_state  = state_q;

endmodule
